// File: rtl/scalar_divide_seq.sv
// Sequential complex-matrix-by-scalar divider: LANES restoring dividers process
// the real/imag components group by group, then hold the quotient matrix for an AXI-Stream handshake.
module scalar_divide_seq #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 32,
    parameter int LANES        = 4
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] s_axis_tdata,
    input  logic                                         s_axis_tvalid,
    input  logic                                         s_axis_tlast,
    input  logic                                         s_axis_tuser,
    output logic                                         s_axis_tready,
    input  logic [ELEMENT_SIZE/2-1:0]                    divisor,
    output logic [MAT_WIDTH*MAT_HEIGHT*ELEMENT_SIZE-1:0] m_axis_tdata,
    output logic                                         m_axis_tvalid,
    output logic                                         m_axis_tlast,
    output logic                                         m_axis_tuser,
    input  logic                                         m_axis_tready,
    output logic                                         div_err
);

    localparam int N  = MAT_WIDTH * MAT_HEIGHT;
    localparam int C  = ELEMENT_SIZE / 2;
    localparam int DW = N * ELEMENT_SIZE;
    localparam int G  = (2 * N) / LANES;
    localparam int BW = (C > 1) ? $clog2(C) : 1;
    localparam int GW = $clog2(G + 1);

    localparam logic [BW-1:0] LAST_BIT = BW'(C - 1);
    localparam logic [GW-1:0] GRP_END  = GW'(G);
    localparam logic [C-1:0]  Q_MAX    = {1'b0, {(C-1){1'b1}}};
    localparam logic [C-1:0]  Q_MIN    = {1'b1, {(C-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        OUTPUT
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q;
    logic [BW-1:0]   bit_q;
    logic [GW-1:0]   grp_q;
    logic            err_q;
    logic            tlast_q, tuser_q;
    logic [DW-1:0]   din_q;
    logic [C-1:0]    dsr_q;
    logic [DW-1:0]   res_q;
    logic [C-1:0]    rem_q [LANES];
    logic [C-1:0]    quo_q [LANES];

    logic [DW-1:0]   m_tdata_q;
    logic            m_tlast_q, m_tuser_q, m_err_q;

    logic            accept, step, last_bit, load_out;
    logic [GW-1:0]   grp_sel;
    logic [C-1:0]    dsr_mag;
    logic [C-1:0]    a_val   [LANES];
    logic [C-1:0]    a_mag   [LANES];
    logic [C-1:0]    rem_src [LANES];
    logic [C-1:0]    quo_src [LANES];
    logic [C:0]      trial   [LANES];
    logic [C-1:0]    rem_nx  [LANES];
    logic [C-1:0]    quo_nx  [LANES];
    logic [C-1:0]    lane_res[LANES];
    logic [LANES-1:0] lane_err;

    assign accept   = (state_q == IDLE) && ready_q && s_axis_tvalid;
    assign step     = (state_q == DIVIDE) && (grp_q != GRP_END);
    assign last_bit = (bit_q == LAST_BIT);
    // The extra DIVIDE cycle with grp_q == G publishes the finished matrix.
    assign load_out = (state_q == DIVIDE) && (grp_q == GRP_END);

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = DIVIDE;
            DIVIDE:  if (load_out)      state_d = OUTPUT;
            OUTPUT:  if (m_axis_tready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        dsr_mag = dsr_q[C-1] ? (-dsr_q) : dsr_q;
        grp_sel = (grp_q == GRP_END) ? '0 : grp_q;
        lane_err = '0;
        for (int l = 0; l < LANES; l++) begin
            a_val[l]   = din_q[(int'(grp_sel) * LANES + l) * C +: C];
            a_mag[l]   = a_val[l][C-1] ? (-a_val[l]) : a_val[l];
            // Bit 0 of a group starts from the raw operand instead of the lane registers.
            rem_src[l] = (bit_q == '0) ? '0 : rem_q[l];
            quo_src[l] = (bit_q == '0) ? a_mag[l] : quo_q[l];
            trial[l]   = {rem_src[l], quo_src[l][C-1]};
            if (trial[l] >= {1'b0, dsr_mag}) begin
                rem_nx[l] = C'(trial[l] - {1'b0, dsr_mag});
                quo_nx[l] = {quo_src[l][C-2:0], 1'b1};
            end else begin
                rem_nx[l] = trial[l][C-1:0];
                quo_nx[l] = {quo_src[l][C-2:0], 1'b0};
            end

            lane_res[l] = (a_val[l][C-1] ^ dsr_q[C-1]) ? (-quo_nx[l]) : quo_nx[l];
            if (dsr_q == '0) begin
                lane_res[l] = a_val[l][C-1] ? Q_MIN : Q_MAX;
                lane_err[l] = 1'b1;
            end else if ((quo_nx[l] == Q_MIN) && !(a_val[l][C-1] ^ dsr_q[C-1])) begin
                lane_res[l] = Q_MAX;
                lane_err[l] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            bit_q     <= '0;
            grp_q     <= '0;
            err_q     <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            m_tdata_q <= '0;
            m_tlast_q <= 1'b0;
            m_tuser_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            if (accept) begin
                bit_q   <= '0;
                grp_q   <= '0;
                err_q   <= 1'b0;
                tlast_q <= s_axis_tlast;
                tuser_q <= s_axis_tuser;
            end else if (step) begin
                if (last_bit) begin
                    bit_q <= '0;
                    grp_q <= grp_q + 1'b1;
                    err_q <= err_q | (|lane_err);
                end else begin
                    bit_q <= bit_q + 1'b1;
                end
            end
            if (load_out) begin
                m_tdata_q <= res_q;
                m_tlast_q <= tlast_q;
                m_tuser_q <= tuser_q;
                m_err_q   <= err_q;
            end
        end
    end

    // NOTE: pure datapath storage is left unreset; control never consumes it before it is loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            din_q <= s_axis_tdata;
            dsr_q <= divisor;
        end
        if (step) begin
            for (int l = 0; l < LANES; l++) begin
                rem_q[l] <= rem_nx[l];
                quo_q[l] <= quo_nx[l];
                if (last_bit) begin
                    res_q[(int'(grp_q) * LANES + l) * C +: C] <= lane_res[l];
                end
            end
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (state_q == OUTPUT);
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign div_err       = m_err_q;

endmodule

// File: tb/tb_scalar_divide_seq.sv
// Directed bench for scalar_divide_seq with default parameters (4x4 matrix,
// 16-bit components, 4 lanes); expected quotients are worked out by hand.
module tb_scalar_divide_seq;

    localparam int W = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [15:0]   divisor;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic          div_err;

    int checks = 0;
    int errors = 0;

    scalar_divide_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .divisor       (divisor),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .div_err       (div_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] fill(input logic [31:0] e);
        return {16{e}};
    endfunction

    task automatic send(input logic [W-1:0] d, input logic [15:0] dv, input logic last, input logic user);
        int n = 0;
        while (!s_axis_tready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_send", s_axis_tready, 1'b1);
        s_axis_tdata  = d;
        divisor       = dv;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        check("ready_low_in_divide", s_axis_tready, 1'b0);
    endtask

    task automatic wait_out(input bit toggle, output int lat);
        lat = 0;
        while (lat < 300) begin
            @(posedge clk); #1; lat++;
            if (toggle) begin
                divisor      = 16'($urandom);
                s_axis_tdata = ~s_axis_tdata;
            end
            if (m_axis_tvalid) break;
        end
    endtask

    task automatic transfer(input logic [W-1:0] exp_data);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        check("tvalid_drop", m_axis_tvalid, 1'b0);
        check("ready_return", s_axis_tready, 1'b1);
        check("tdata_retained", m_axis_tdata, exp_data);
    endtask

    task automatic run(input string tag, input logic [W-1:0] d, input logic [15:0] dv,
                       input logic last, input logic user, input bit toggle,
                       input logic [W-1:0] exp_data, input logic exp_err);
        int lat;
        send(d, dv, last, user);
        wait_out(toggle, lat);
        check({tag, "_latency"}, lat, 129);
        check({tag, "_data"}, m_axis_tdata, exp_data);
        check({tag, "_err"}, div_err, exp_err);
        check({tag, "_tlast"}, m_axis_tlast, last);
        check({tag, "_tuser"}, m_axis_tuser, user);
    endtask

    initial begin
        logic [W-1:0] d, e;

        reset_n       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        divisor       = '0;
        m_axis_tready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_axis_tready, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tuser", m_axis_tuser, 1'b0);
        check("rst_err", div_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_first_edge", s_axis_tready, 1'b0);
        @(posedge clk); #1;
        check("ready_after_first_edge", s_axis_tready, 1'b1);

        // 0x0100/256 = 1, 0xFF00/256 = -1; then hold the output under backpressure
        run("basic", fill(32'hFF00_0100), 16'h0100, 1'b1, 1'b0, 1'b0, fill(32'hFFFF_0001), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_tvalid", m_axis_tvalid, 1'b1);
            check("stall_data", m_axis_tdata, fill(32'hFFFF_0001));
            check("stall_meta", {m_axis_tlast, m_axis_tuser, div_err}, 3'b100);
            check("stall_ready", s_axis_tready, 1'b0);
        end
        transfer(fill(32'hFFFF_0001));

        // -7/2 = -3, 7/2 = 3 with divisor and tdata churning during DIVIDE
        d = '0; d[31:0] = 32'h0007_FFF9;
        e = '0; e[31:0] = 32'h0003_FFFD;
        run("trunc_pos", d, 16'h0002, 1'b0, 1'b1, 1'b1, e, 1'b0);
        transfer(e);

        e = '0; e[31:0] = 32'hFFFD_0003;
        run("trunc_neg", d, 16'hFFFE, 1'b0, 1'b0, 1'b0, e, 1'b0);
        transfer(e);

        // -32768 / -1 saturates
        d = '0; d[31:0] = 32'h0000_8000;
        e = '0; e[31:0] = 32'h0000_7FFF;
        run("overflow", d, 16'hFFFF, 1'b0, 1'b0, 1'b0, e, 1'b1);
        transfer(e);

        // divide by zero: 5 -> 0x7FFF, -5 -> 0x8000
        run("div_zero", fill(32'hFFFB_0005), 16'h0000, 1'b0, 1'b0, 1'b0, fill(32'h8000_7FFF), 1'b1);
        transfer(fill(32'h8000_7FFF));

        // first and last elements, divisor 7: 32767/7=4681, -32768/7=-4681, 100/7=14, -100/7=-14
        d = '0; d[31:0] = 32'h8000_7FFF; d[511:480] = 32'hFF9C_0064;
        e = '0; e[31:0] = 32'hEDB7_1249; e[511:480] = 32'hFFF2_000E;
        run("edges", d, 16'h0007, 1'b0, 1'b0, 1'b0, e, 1'b0);
        transfer(e);

        // reset in the middle of DIVIDE discards the matrix
        send(fill(32'hFF00_0100), 16'h0100, 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
        check("mid_rst_ready", s_axis_tready, 1'b0);
        check("mid_rst_tdata", m_axis_tdata, '0);
        check("mid_rst_err", div_err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ready_rise", s_axis_tready, 1'b1);
        repeat (150) @(posedge clk);
        #1;
        check("mid_rst_no_output", m_axis_tvalid, 1'b0);

        run("after_rst", fill(32'hFF00_0100), 16'h0100, 1'b1, 1'b1, 1'b0, fill(32'hFFFF_0001), 1'b0);
        transfer(fill(32'hFFFF_0001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scalar_divide_seq.md
SCALAR_DIVIDE_SEQ -- requirements
Module: scalar_divide_seq

Interface
REQ-001 Parameter MAT_WIDTH, default 4: matrix columns.
REQ-002 Parameter MAT_HEIGHT, default 4: matrix rows.
REQ-003 Parameter ELEMENT_SIZE, default 32: complex element width; imag in upper half, real in lower half, each C = ELEMENT_SIZE/2 bits, two's complement.
REQ-004 Parameter LANES, default 4: parallel component dividers; 2*MAT_WIDTH*MAT_HEIGHT SHALL be divisible by LANES.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 s_axis_tdata  input  N*ELEMENT_SIZE (N = MAT_WIDTH*MAT_HEIGHT)  input matrix; element (i,j) at index i*MAT_WIDTH+j.
REQ-008 s_axis_tvalid, s_axis_tlast, s_axis_tuser  input  1 each  input beat qualifiers.
REQ-009 s_axis_tready  output  1  block can accept a matrix.
REQ-010 divisor  input  C  signed runtime divisor, sampled on input acceptance.
REQ-011 m_axis_tdata  output  N*ELEMENT_SIZE  quotient matrix, same layout as input.
REQ-012 m_axis_tvalid, m_axis_tlast, m_axis_tuser  output  1 each  output beat qualifiers.
REQ-013 m_axis_tready  input  1  downstream accept.
REQ-014 div_err  output  1  divide-by-zero or overflow occurred in the current output matrix.

Function
REQ-015 States: IDLE, DIVIDE, OUTPUT; s_axis_tready SHALL be 1 exactly in IDLE.
REQ-016 IDLE: on s_axis_tvalid=1 (acceptance), capture tdata, divisor, tlast, tuser; clear group counter and error flag; go to DIVIDE.
REQ-017 DIVIDE: components processed in G = 2N/LANES groups, lowest component index first (real then imag of element 0, ...); each group uses C cycles of restoring division on magnitudes, one quotient bit per cycle per lane.
REQ-018 After G*C DIVIDE cycles the block SHALL enter OUTPUT with m_axis_tvalid=1; m_axis_tvalid rises exactly G*C+1 cycles after the acceptance edge (129 for defaults).
REQ-019 Quotient SHALL truncate toward zero; result sign = sign(dividend) XOR sign(divisor); zero dividend yields 0.
REQ-020 Overflow (dividend = -2^(C-1), divisor = -1) SHALL yield 2^(C-1)-1 and set div_err.
REQ-021 divisor = 0: non-negative dividend yields 2^(C-1)-1, negative yields -2^(C-1); div_err set.
REQ-022 OUTPUT: m_axis_tdata, tlast, tuser, div_err held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 OUTPUT with m_axis_tready=1: transfer completes; next state IDLE; m_axis_tvalid=0 the following cycle; s_axis_tready=1 the following cycle (no same-cycle turnaround).
REQ-024 Changes to divisor or s_axis_tdata after acceptance SHALL not affect the in-flight matrix.
REQ-025 m_axis_tdata SHALL retain the last transferred matrix until the next OUTPUT entry.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, div_err=0, m_axis_tdata=0, counters=0.
REQ-027 s_axis_tready SHALL rise on the first clk edge after reset_n deasserts.
REQ-028 Reset during DIVIDE or OUTPUT SHALL discard the in-flight matrix; no partial output emitted.

Verification
REQ-029 Defaults, all elements 0xFF00_0100, divisor 256 -> all elements 0xFFFF_0001, m_axis_tvalid rises 129 cycles after acceptance, div_err=0.
REQ-030 Element real=-7, imag=7, divisor 2 -> real=-3 (0xFFFD), imag=3; divisor -2 -> real=3, imag=-3.
REQ-031 Real=0x8000, divisor 0xFFFF -> real=0x7FFF, div_err=1; divisor 0, real=5, imag=-5 -> 0x7FFF, 0x8000, div_err=1.
REQ-032 m_axis_tready held 0 for 10 cycles in OUTPUT -> tdata/tlast/tuser/div_err stable, s_axis_tready=0; divisor toggled during DIVIDE -> result unchanged.
REQ-033 reset_n pulsed low at cycle 50 of DIVIDE -> outputs zero immediately, no m_axis_tvalid; next matrix processed correctly with tlast=1, tuser=1 propagated.
